// File: rtl/hilo_muldiv.sv
// Multi-cycle multiply/divide unit owning the MIPS HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, 32 iterations plus a sign-fix cycle.
module hilo_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               a_neg_q, a_neg_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               is_signed;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   a_orig;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        a_neg_d  = a_neg_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        prod_d   = prod_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;

        is_signed = (op == OpMult) || (op == OpDiv);
        // Multiply: upper half accumulates, lower half shifts the multiplier out.
        sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mag_a_q} : '0);
        // Divide: upper half is the remainder, lower half shifts dividend out / quotient in.
        shifted   = prod_q[2*WIDTH-1:WIDTH-1];
        diff      = shifted - {1'b0, mag_b_q};
        ge        = ~diff[WIDTH];
        prod_neg  = neg_q ? -prod_q : prod_q;
        quo_fix   = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
        rem_fix   = a_neg_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
        a_orig    = a_neg_q ? -mag_a_q : mag_a_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    case (op)
                        OpMthi: hi_d = a;
                        OpMtlo: lo_d = a;
                        OpMult, OpMultu, OpDiv, OpDivu: begin
                            mag_a_d  = (is_signed && a[WIDTH-1]) ? -a : a;
                            mag_b_d  = (is_signed && b[WIDTH-1]) ? -b : b;
                            neg_d    = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            a_neg_d  = is_signed && a[WIDTH-1];
                            is_div_d = (op == OpDiv) || (op == OpDivu);
                            cnt_d    = '0;
                            prod_d   = {{WIDTH{1'b0}},
                                        ((op == OpDiv) || (op == OpDivu)) ? mag_a_d : mag_b_d};
                            state_d  = StCalc;
                        end
                        default: ;
                    endcase
                end
            end
            StCalc: begin
                if (is_div_q) begin
                    prod_d = {ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0], prod_q[WIDTH-2:0], ge};
                end else begin
                    prod_d = {sum, prod_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (!is_div_q) begin
                    hi_d = prod_neg[2*WIDTH-1:WIDTH];
                    lo_d = prod_neg[WIDTH-1:0];
                end else if (mag_b_q == '0) begin
                    hi_d = a_orig;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            prod_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            a_neg_q  <= a_neg_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            prod_q   <= prod_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed vector table plus hand-written
// sequences for start-while-busy and asynchronous reset mid-calculation.
module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [0:14];

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Called at a point just after a rising edge; start is accepted at the next edge.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input string name);
        int          done_at;
        int          busy_cnt;
        logic        held;
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;
        hold_hi = hi;
        hold_lo = lo;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        if (o >= 3'd1 && o <= 3'd4) begin
            done_at  = -1;
            busy_cnt = 0;
            held     = 1'b1;
            for (int k = 0; k < 40; k++) begin
                if (done) begin
                    done_at = k;
                    break;
                end
                if (busy) busy_cnt++;
                if (hi !== hold_hi || lo !== hold_lo) held = 1'b0;
                @(posedge clk);
                #1;
            end
            check({name, " done edge"}, 32'(done_at), 32'd33);
            check({name, " busy cycles"}, 32'(busy_cnt), 32'd33);
            check({name, " hilo held"}, {31'd0, held}, 32'd1);
            check({name, " busy after fix"}, {31'd0, busy}, 32'd0);
        end else begin
            check({name, " busy"}, {31'd0, busy}, 32'd0);
            check({name, " done"}, {31'd0, done}, 32'd0);
        end
        check({name, " hi"}, hi, eh);
        check({name, " lo"}, lo, el);
    endtask

    initial begin
        int          n;
        logic [31:0] hold_hi;

        vecs[0]  = {3'd5, 32'h12345678, 32'h0,        32'h12345678, 32'h00000000};
        vecs[1]  = {3'd6, 32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0};
        vecs[2]  = {3'd4, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[3]  = {3'd0, 32'h11111111, 32'h22222222, 32'd2,        32'd14};
        vecs[4]  = {3'd7, 32'h33333333, 32'h44444444, 32'd2,        32'd14};
        vecs[5]  = {3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[6]  = {3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[7]  = {3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8]  = {3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[9]  = {3'd4, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF};
        vecs[10] = {3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[11] = {3'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[12] = {3'd3, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[13] = {3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[14] = {3'd3, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2};

        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                   $sformatf("v%0d", i));
        end

        // Start pulses during CALC must be ignored, including an MTHI.
        hold_hi = hi;
        start = 1'b1;
        op    = 3'd2;
        a     = 32'd3;
        b     = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 3'd5;
        a     = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        check("ignored mthi hi", hi, hold_hi);
        op = 3'd1;
        a  = 32'hFFFFFFFF;
        b  = 32'h7;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 7;
        while (!done && n < 45) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("busy-start done edge", 32'(n), 32'd33);
        check("busy-start hi", hi, 32'd0);
        check("busy-start lo", lo, 32'd12);

        // Asynchronous reset in the middle of CALC.
        run_op(3'd5, 32'h55, 32'h0, 32'h55, 32'd12, "mthi pre-reset");
        start = 1'b1;
        op    = 3'd2;
        a     = 32'd3;
        b     = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset done", {31'd0, done}, 32'd0);
        check("midreset hi", hi, 32'd0);
        check("midreset lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(3'd2, 32'd3, 32'd4, 32'd0, 32'd12, "multu after reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Multi-cycle multiply/divide unit that owns the architectural HI and LO registers of the MIPS datapath. It is the responder for every HI/LO-producing request: MULT, MULTU, DIV, DIVU, MTHI and MTLO. Its hi/lo outputs feed the ALU path for MFHI/MFLO. The pipeline issues requests with a start/busy handshake, so no HI/LO state lives in the combinational ALU.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is supported.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request strobe; sampled only when busy=0.
- op  in  3  opcode: 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO. Codes 000 and 111 are no-ops.
- a  in  32  rs operand (dividend / multiplicand / MT source).
- b  in  32  rt operand (divisor / multiplier).
- busy  out  1  unit is computing; start is ignored.
- done  out  1  one-cycle pulse when a mult/div result is written to HI/LO.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start=1, op=MTHI: hi<=a at that edge. Stay IDLE. busy and done stay 0.
- IDLE, start=1, op=MTLO: lo<=a at that edge. Otherwise the same as MTHI.
- IDLE, start=1, op in mult/div: latch the operand magnitudes, the result signs and the op. Clear the 5-bit iteration counter. Go to CALC.
- Signed ops (MULT, DIV) take magnitudes as |x| = x[31] ? ~x+1 : x, treated as unsigned 32-bit. |0x80000000| = 0x80000000.
- CALC, multiply: radix-2 shift-add, one partial product per cycle, into a 64-bit accumulator.
- CALC, divide: restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
- CALC runs exactly 32 iterations. When counter=31, go to FIX.
- FIX, MULT: negate the 64-bit product iff a[31]^b[31].
- FIX, DIV: negate the quotient iff a[31]^b[31]. Negate the remainder iff a[31]. Quotient truncates toward zero; remainder takes the dividend's sign.
- FIX, all ops: write HI = product[63:32] or remainder, and LO = product[31:0] or quotient. Assert done. Return to IDLE.
- Divide by zero (b=0, DIV or DIVU): HI=a unchanged, LO=0xFFFFFFFF. No sign fix is applied.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This is not an error.
- No-op codes, or start while busy: ignored. No state change.
- hi/lo hold their old values throughout CALC. They change only in FIX, or on an MT edge.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0, state=IDLE.
- Reset is asserted asynchronously at any point, including mid-CALC or in FIX. It aborts the operation immediately and the result is never written.
- Mult/div latency, with start accepted at edge E0:
  - busy=1 after E0.
  - CALC iterations on E1..E32.
  - FIX at E33 writes hi/lo. After E33: busy=0, done=1 for exactly one cycle.
  - A new start may be accepted at E34, the edge where done is high.
- MTHI/MTLO latency: the new value is visible on hi/lo right after the accepting edge. Back-to-back MT requests are accepted every cycle.
- busy is a registered output, derived from state≠IDLE.
- done is registered and asserted only in the cycle after the FIX edge.
- Operands a/b may change freely after the accepting edge; they are latched at that edge.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done 34th cycle after start, HI=0xFFFFFFFE, LO=0x00000001; busy high for exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Also MULT 0x80000000×0x80000000 -> HI=0x40000000, LO=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=0 -> HI=7, LO=0xFFFFFFFF.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles -> hi/lo update on each edge, busy/done stay 0. Then DIVU 100/7 -> HI=2, LO=14.
- Start pulsed during CALC (any op, including MTHI) -> ignored; the original result and hi are unchanged.
- Reset asserted mid-CALC of MULTU 3×4 -> busy, done, hi, lo all 0 immediately. After release, a fresh MULTU 3×4 -> LO=12, HI=0.
